instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Initiator side of the instruction memory read interface: owns the PC, drives the word address into instructionmemory and captures the returned instruction into the IF/ID pipeline register.
- Handles stall, flush, branch/jump redirect and halt from downstream stages.
- Sits at the front of the 5-stage pipeline, feeding the decode stage.

Parameters:
- ADDR_BITS, 12, byte-address width of instruction memory; word address is pc[ADDR_BITS-1:2].
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, bubble encoding (sll $0,$0,0) inserted on flush, redirect and halt.

Ports:
- CLK  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset; asserted at 0.
- stall  in  1  hazard unit: hold PC and IF/ID.
- flush  in  1  squash the IF/ID contents.
- redirect  in  1  taken branch/jump: load redirect_target into PC.
- redirect_target  in  32  byte address of the new PC.
- halt  in  1  stop fetching until reset.
- instructionAddress  out  ADDR_BITS-2  word address to instruction memory.
- instruction  in  32  instruction word from memory (combinational read, same cycle).
- if_id_instr  out  32  registered instruction for decode.
- if_id_pc_plus4  out  32  registered PC+4 of that instruction.
- if_id_valid  out  1  IF/ID holds a real instruction.
- pc  out  32  current PC.
- halted  out  1  high in HALT state.

Behaviour:
- Reset (asynchronous, immediate, also mid-operation): pc=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc_plus4=0, if_id_valid=0, halted=0, state=BOOT.
- instructionAddress = pc[ADDR_BITS-1:2], purely combinational.
- Fetch latency: the instruction at pc appears on if_id_instr one edge later.
- States:
  - BOOT: one cycle after reset release; no capture, pc holds, valid stays 0; go to RUN unconditionally, or to HALT if halt=1.
  - RUN: normal fetch.
  - HALT: pc holds, IF/ID = NOP_INSTR with valid=0, halted=1; all inputs ignored; exit only by reset.
- RUN priority per edge, highest first:
  - halt: go to HALT; pc holds; IF/ID becomes bubble.
  - redirect: pc <= {redirect_target[31:2],2'b00}; IF/ID becomes bubble (wrong-path instruction dropped); stall ignored.
  - flush with stall: IF/ID becomes bubble; pc holds.
  - flush without stall: IF/ID becomes bubble; pc <= pc+4.
  - stall only: pc and IF/ID hold, including if_id_valid.
  - none: pc <= pc+4; if_id_instr <= instruction; if_id_pc_plus4 <= pc+4; if_id_valid <= 1.
- Width rules:
  - pc+4 is computed mod 2^32.
  - Memory address wraps mod 2^ADDR_BITS bytes: pc=0x0000_0FFC, then 0x0000_1000 drives word address 0x3FF, then 0x000.
- A misaligned redirect_target has its low 2 bits cleared; no exception is raised.
- No combinational path from stall/flush/redirect/halt to any output.

Decomposition:
- Shared package holds: NOP_INSTR; state encoding BOOT=2'd0, RUN=2'd1, HALT=2'd2; and the word-address slice width constant.
- One natural sub-module: if_id_register. It holds instr, pc_plus4 and valid, and takes hold/bubble controls.
- PC logic and the state machine stay in the top-level module.

Test Plan:
- Reset sequence: hold reset=0 for 100 ns, then release. First edge leaves valid=0 (BOOT). Next edges give pc 0,4,8,12; if_id_instr equals memory words 0..2 in order with valid=1; if_id_pc_plus4 = 4,8,12.
- Stall: at pc=8, assert stall for 3 cycles. pc stays 8 and IF/ID holds the word at address 4 with valid=1. After release, pc goes to 12 and IF/ID holds word 8.
- Redirect with stall:
  - At pc=16, set redirect=1, target=0x0000_0042, stall=1.
  - Next edge: pc=0x40, IF/ID=NOP_INSTR, valid=0.
  - Edge after: IF/ID = word 0x40, if_id_pc_plus4 = 0x44.
- Wrap: redirect to 0x0000_0FFC, then run 2 cycles. instructionAddress goes 0x3FF, then 0x000; pc goes 0x1000, then 0x1004.
- Flush versus stall: flush=1 with stall=0 gives bubble and pc+4. flush=1 with stall=1 gives bubble and pc unchanged.
- Halt and reset mid-run:
  - halt=1 at pc=0x20: halted=1, pc stays 0x20, valid=0; redirect is then ignored.
  - Asserting reset between clock edges immediately gives pc=0, halted=0, valid=0.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: bubble encoding, FSM
// state encoding and the word-address width helper.
package instruction_fetch_unit_pkg;

  localparam logic [31:0] IFU_NOP_INSTR = 32'h0000_0000;
  localparam int unsigned IFU_DEFAULT_ADDR_BITS = 12;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } ifu_state_e;

  // Instruction memory is word addressed, so the two byte-offset bits drop out.
  function automatic int unsigned word_addr_bits(input int unsigned addr_bits);
    return addr_bits - 2;
  endfunction

  localparam int unsigned IFU_WORD_ADDR_BITS = word_addr_bits(IFU_DEFAULT_ADDR_BITS);

endpackage

// File: rtl/instruction_fetch_unit_if_id_register.sv
// IF/ID pipeline register: loads a fetched instruction, holds it, or is
// replaced by a bubble. Bubble wins over load; neither means hold.
module if_id_register
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = IFU_NOP_INSTR
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        bubble_i,
  input  logic        load_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_plus4_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        valid_q, valid_d;

  always_comb begin
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (bubble_i) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (load_i) begin
      instr_d    = instr_i;
      pc_plus4_d = pc_plus4_i;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      instr_q    <= NOP_INSTR;
      pc_plus4_q <= 32'h0000_0000;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign instr_o    = instr_q;
  assign pc_plus4_o = pc_plus4_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Front of the pipeline: owns the PC, drives the instruction memory word
// address and fills IF/ID, honouring halt, redirect, flush and stall.
//
// state | meaning
// BOOT  | first cycle after reset release, no capture
// RUN   | normal fetch
// HALT  | fetching stopped until reset, IF/ID held as bubble
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_BITS = IFU_DEFAULT_ADDR_BITS,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = IFU_NOP_INSTR
) (
  input  logic                                CLK,
  input  logic                                reset,
  input  logic                                stall,
  input  logic                                flush,
  input  logic                                redirect,
  input  logic [31:0]                         redirect_target,
  input  logic                                halt,
  output logic [word_addr_bits(ADDR_BITS)-1:0] instructionAddress,
  input  logic [31:0]                         instruction,
  output logic [31:0]                         if_id_instr,
  output logic [31:0]                         if_id_pc_plus4,
  output logic                                if_id_valid,
  output logic [31:0]                         pc,
  output logic                                halted
);

  ifu_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4;
  logic        bubble;
  logic        load;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    bubble  = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      BOOT: begin
        state_d = halt ? HALT : RUN;
      end
      RUN: begin
        if (halt) begin
          state_d = HALT;
          bubble  = 1'b1;
        end else if (redirect) begin
          // Misaligned targets are silently word-aligned.
          pc_d   = redirect_target & ~32'h0000_0003;
          bubble = 1'b1;
        end else if (flush) begin
          bubble = 1'b1;
          if (!stall) pc_d = pc_plus4;
        end else if (!stall) begin
          pc_d = pc_plus4;
          load = 1'b1;
        end
      end
      HALT: begin
        bubble = 1'b1;
      end
      default: begin
        state_d = HALT;
        bubble  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  if_id_register #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .CLK        (CLK),
    .reset      (reset),
    .bubble_i   (bubble),
    .load_i     (load),
    .instr_i    (instruction),
    .pc_plus4_i (pc_plus4),
    .instr_o    (if_id_instr),
    .pc_plus4_o (if_id_pc_plus4),
    .valid_o    (if_id_valid)
  );

  assign instructionAddress = pc_q[ADDR_BITS-1:2];
  assign pc                 = pc_q;
  assign halted             = (state_q == HALT);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit; memory returns 0xAB00_0000 | byte address.
module tb_instruction_fetch_unit;

  logic        CLK = 1'b0;
  logic        reset;
  logic        stall, flush, redirect, halt;
  logic [31:0] redirect_target;
  logic [9:0]  instructionAddress;
  logic [31:0] instruction;
  logic [31:0] if_id_instr, if_id_pc_plus4, pc;
  logic        if_id_valid, halted;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  assign instruction = 32'hAB00_0000 | {20'h0, instructionAddress, 2'b00};

  instruction_fetch_unit dut (
    .CLK                (CLK),
    .reset              (reset),
    .stall              (stall),
    .flush              (flush),
    .redirect           (redirect),
    .redirect_target    (redirect_target),
    .halt               (halt),
    .instructionAddress (instructionAddress),
    .instruction        (instruction),
    .if_id_instr        (if_id_instr),
    .if_id_pc_plus4     (if_id_pc_plus4),
    .if_id_valid        (if_id_valid),
    .pc                 (pc),
    .halted             (halted)
  );

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic clear_inputs();
    stall = 0; flush = 0; redirect = 0; halt = 0; redirect_target = 32'h0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 0;
    #100;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", if_id_valid); end
    checks++; if (if_id_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", if_id_instr); end
    checks++; if (if_id_pc_plus4 !== 32'h0) begin errors++; $display("FAIL reset_pc4: got %h expected 0", if_id_pc_plus4); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
    @(negedge CLK);
    reset = 1;
    tick();
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL boot_valid: got %b expected 0", if_id_valid); end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL boot_pc: got %h expected 0", pc); end
    tick();
    checks++; if (pc !== 32'h4) begin errors++; $display("FAIL run1_pc: got %h expected 4", pc); end
    checks++; if (if_id_instr !== 32'hAB00_0000) begin errors++; $display("FAIL run1_instr: got %h expected AB000000", if_id_instr); end
    checks++; if (if_id_pc_plus4 !== 32'h4) begin errors++; $display("FAIL run1_pc4: got %h expected 4", if_id_pc_plus4); end
    checks++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL run1_valid: got %b expected 1", if_id_valid); end
    tick();
    checks++; if (pc !== 32'h8) begin errors++; $display("FAIL run2_pc: got %h expected 8", pc); end
    checks++; if (if_id_instr !== 32'hAB00_0004) begin errors++; $display("FAIL run2_instr: got %h expected AB000004", if_id_instr); end
    checks++; if (if_id_pc_plus4 !== 32'h8) begin errors++; $display("FAIL run2_pc4: got %h expected 8", if_id_pc_plus4); end
  endtask

  task automatic test_stall();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (pc !== 32'h8) begin errors++; $display("FAIL stall_pc[%0d]: got %h expected 8", i, pc); end
      checks++; if (if_id_instr !== 32'hAB00_0004 || if_id_valid !== 1'b1)
        begin errors++; $display("FAIL stall_ifid[%0d]: got %h/%b expected AB000004/1", i, if_id_instr, if_id_valid); end
    end
    stall = 0;
    tick();
    checks++; if (pc !== 32'hC) begin errors++; $display("FAIL unstall_pc: got %h expected C", pc); end
    checks++; if (if_id_instr !== 32'hAB00_0008) begin errors++; $display("FAIL unstall_instr: got %h expected AB000008", if_id_instr); end
    checks++; if (if_id_pc_plus4 !== 32'hC) begin errors++; $display("FAIL unstall_pc4: got %h expected C", if_id_pc_plus4); end
  endtask

  task automatic test_redirect_stall();
    tick();
    checks++; if (pc !== 32'h10) begin errors++; $display("FAIL pre_redir_pc: got %h expected 10", pc); end
    redirect = 1; redirect_target = 32'h0000_0042; stall = 1;
    tick();
    clear_inputs();
    checks++; if (pc !== 32'h40) begin errors++; $display("FAIL redir_pc: got %h expected 40", pc); end
    checks++; if (if_id_instr !== 32'h0 || if_id_valid !== 1'b0)
      begin errors++; $display("FAIL redir_bubble: got %h/%b expected 0/0", if_id_instr, if_id_valid); end
    tick();
    checks++; if (if_id_instr !== 32'hAB00_0040) begin errors++; $display("FAIL redir_instr: got %h expected AB000040", if_id_instr); end
    checks++; if (if_id_pc_plus4 !== 32'h44) begin errors++; $display("FAIL redir_pc4: got %h expected 44", if_id_pc_plus4); end
    checks++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL redir_valid: got %b expected 1", if_id_valid); end
  endtask

  task automatic test_wrap();
    redirect = 1; redirect_target = 32'h0000_0FFC;
    tick();
    clear_inputs();
    checks++; if (instructionAddress !== 10'h3FF) begin errors++; $display("FAIL wrap_addr0: got %h expected 3FF", instructionAddress); end
    tick();
    checks++; if (pc !== 32'h1000) begin errors++; $display("FAIL wrap_pc1: got %h expected 1000", pc); end
    checks++; if (instructionAddress !== 10'h000) begin errors++; $display("FAIL wrap_addr1: got %h expected 000", instructionAddress); end
    checks++; if (if_id_instr !== 32'hAB00_0FFC) begin errors++; $display("FAIL wrap_instr1: got %h expected AB000FFC", if_id_instr); end
    tick();
    checks++; if (pc !== 32'h1004) begin errors++; $display("FAIL wrap_pc2: got %h expected 1004", pc); end
    checks++; if (if_id_instr !== 32'hAB00_0000) begin errors++; $display("FAIL wrap_instr2: got %h expected AB000000", if_id_instr); end
    checks++; if (if_id_pc_plus4 !== 32'h1004) begin errors++; $display("FAIL wrap_pc4: got %h expected 1004", if_id_pc_plus4); end
  endtask

  task automatic test_flush();
    flush = 1;
    tick();
    checks++; if (pc !== 32'h1008) begin errors++; $display("FAIL flush_pc: got %h expected 1008", pc); end
    checks++; if (if_id_instr !== 32'h0 || if_id_valid !== 1'b0)
      begin errors++; $display("FAIL flush_bubble: got %h/%b expected 0/0", if_id_instr, if_id_valid); end
    stall = 1;
    tick();
    checks++; if (pc !== 32'h1008) begin errors++; $display("FAIL flush_stall_pc: got %h expected 1008", pc); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL flush_stall_valid: got %b expected 0", if_id_valid); end
    clear_inputs();
    tick();
    checks++; if (pc !== 32'h100C) begin errors++; $display("FAIL post_flush_pc: got %h expected 100C", pc); end
    checks++; if (if_id_instr !== 32'hAB00_0008 || if_id_valid !== 1'b1)
      begin errors++; $display("FAIL post_flush_ifid: got %h/%b expected AB000008/1", if_id_instr, if_id_valid); end
  endtask

  task automatic test_halt_reset();
    redirect = 1; redirect_target = 32'h20;
    tick();
    clear_inputs();
    halt = 1;
    tick();
    halt = 0;
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag: got %b expected 1", halted); end
    checks++; if (pc !== 32'h20) begin errors++; $display("FAIL halt_pc: got %h expected 20", pc); end
    checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0)
      begin errors++; $display("FAIL halt_ifid: got %h/%b expected 0/0", if_id_instr, if_id_valid); end
    redirect = 1; redirect_target = 32'h100; flush = 1;
    tick();
    tick();
    clear_inputs();
    checks++; if (pc !== 32'h20 || halted !== 1'b1)
      begin errors++; $display("FAIL halt_ignore: got %h/%b expected 20/1", pc, halted); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL halt_ignore_valid: got %b expected 0", if_id_valid); end
    #2 reset = 0;
    #1;
    checks++; if (pc !== 32'h0 || halted !== 1'b0 || if_id_valid !== 1'b0)
      begin errors++; $display("FAIL async_reset: got pc=%h halted=%b valid=%b expected 0/0/0", pc, halted, if_id_valid); end
    @(negedge CLK);
    reset = 1;
    tick();
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL reboot_valid: got %b expected 0", if_id_valid); end
    tick();
    checks++; if (if_id_instr !== 32'hAB00_0000 || if_id_valid !== 1'b1 || pc !== 32'h4)
      begin errors++; $display("FAIL reboot_run: got %h/%b/%h expected AB000000/1/4", if_id_instr, if_id_valid, pc); end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect_stall();
    test_wrap();
    test_flush();
    test_halt_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
